// File: rtl/riscv_pkg.sv
// Shared RV32I memory-access definitions: funct3 size codes, the bridge
// state encoding, and the alignment/legality helpers used by the bridge.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        RESP,
        FIN,
        ERR
    } bridge_state_e;

    typedef enum logic {
        ALIGN_OK,
        MISALIGNED
    } align_e;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic align_e align_check(input logic [2:0] funct3,
                                           input logic [1:0] addr_lo);
        align_e res;
        res = ALIGN_OK;
        case (funct3)
            F3_H, F3_HU: if (addr_lo[0])        res = MISALIGNED;
            F3_W:        if (addr_lo != 2'b00)  res = MISALIGNED;
            default:     res = ALIGN_OK;
        endcase
        return res;
    endfunction

    // Unsigned sizes exist only for loads; 011/110/111 are never legal.
    function automatic logic funct3_legal(input logic [2:0] funct3,
                                          input logic       we);
        logic ok;
        case (funct3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_BU, F3_HU:     ok = !we;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// Word-addressed valid/ready request channel plus a separate read-response
// channel between the bridge (master) and a memory slave.
interface mem_bus_bridge_if;

    logic        bus_valid;
    logic        bus_ready;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        input  bus_ready, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wstrb, bus_wdata,
        output bus_ready, bus_rvalid, bus_rdata
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for RV32I loads and stores: store data replication and
// strobe generation, and load lane extraction with sign/zero extension.
// Purely combinational so it can be shared with a future cache datapath.
module lsu_lane_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    output logic [3:0]  store_strb,
    output logic [31:0] store_lanes,
    input  logic [31:0] load_word,
    output logic [31:0] load_data
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Store side: replicate the right-justified data onto every lane it may
    // occupy and enable only the addressed bytes.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        store_strb  = 4'b1111;
        store_lanes = store_data;
        case (funct3)
            F3_B, F3_BU: begin
                store_strb  = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
            end
            F3_H, F3_HU: begin
                store_strb  = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_data[15:0]}};
            end
            default: begin
                store_strb  = 4'b1111;
                store_lanes = store_data;
            end
        endcase
    end

    // Load side: pick the addressed lane, then extend it to 32 bits.
    always_comb begin
        load_byte = load_word[7:0];
        case (addr_lo)
            2'd0:    load_byte = load_word[7:0];
            2'd1:    load_byte = load_word[15:8];
            2'd2:    load_byte = load_word[23:16];
            default: load_byte = load_word[31:24];
        endcase
        load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

        load_data = load_word;
        case (funct3)
            F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
            F3_BU:   load_data = {24'd0, load_byte};
            F3_H:    load_data = {{16{load_half[15]}}, load_half};
            F3_HU:   load_data = {16'd0, load_half};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/mem_bus_bridge.sv
// Bridge between the multicycle core's memory port and a valid/ready memory
// bus. Each core request is validated, issued as one word-aligned bus
// transaction (reads wait for a separate response), and finished with a
// one-cycle core_done pulse, qualified by core_err on misalignment, illegal
// size or bus timeout.
module mem_bus_bridge
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    core_req,
    input  logic                    core_we,
    input  logic [31:0]             core_addr,
    input  logic [31:0]             core_wdata,
    input  logic [2:0]              core_funct3,
    output logic [31:0]             core_rdata,
    output logic                    core_done,
    output logic                    core_err,
    output logic                    core_busy,
    mem_bus_bridge_if.master        bus
);

    localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    bridge_state_e state, state_next;

    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic [31:0] tmo_cnt;

    logic        accept;
    logic        req_bad;
    logic        tmo_expire;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    // The done cycle (FIN/ERR) already returns to IDLE, so a request presented
    // alongside core_done is taken immediately; REQ/RESP ignore core_req.
    assign accept  = core_req && (state == IDLE || state == FIN || state == ERR);
    assign req_bad = !funct3_legal(core_funct3, core_we) ||
                     (align_check(core_funct3, core_addr[1:0]) == MISALIGNED);
    assign tmo_expire = TMO_EN && (tmo_cnt == TMO_LAST);

    lsu_lane_align u_lane_align (
        .funct3      (req_funct3),
        .addr_lo     (req_addr[1:0]),
        .store_data  (req_wdata),
        .store_strb  (lane_strb),
        .store_lanes (lane_wdata),
        .load_word   (bus.bus_rdata),
        .load_data   (lane_rdata)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Capture the request so the bus fields stay stable for its whole life.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_funct3 <= '0;
        end else if (accept) begin
            req_we     <= core_we;
            req_addr   <= core_addr;
            req_wdata  <= core_wdata;
            req_funct3 <= core_funct3;
        end
    end

    // Timeout counter: runs across REQ and RESP, zero everywhere else so it
    // starts from zero on every entry to REQ.
    always_ff @(posedge clk) begin
        if (reset)                             tmo_cnt <= '0;
        else if (state == REQ || state == RESP) tmo_cnt <= tmo_cnt + 32'd1;
        else                                   tmo_cnt <= '0;
    end

    // Load result register; holds until the next successful load.
    always_ff @(posedge clk) begin
        if (reset)                               core_rdata <= '0;
        else if (state == RESP && bus.bus_rvalid) core_rdata <= lane_rdata;
    end

    // Next-state logic; completion in the expiry cycle beats the timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, FIN, ERR: begin
                state_next = IDLE;
                if (core_req) state_next = req_bad ? ERR : REQ;
            end
            REQ: begin
                if (bus.bus_ready) state_next = req_we ? FIN : RESP;
                else if (tmo_expire) state_next = ERR;
            end
            RESP: begin
                if (bus.bus_rvalid)  state_next = FIN;
                else if (tmo_expire) state_next = ERR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from state; bus fields are zero outside REQ.
    always_comb begin
        bus.bus_valid = (state == REQ);
        bus.bus_we    = (state == REQ) && req_we;
        bus.bus_addr  = (state == REQ) ? {req_addr[31:2], 2'b00} : 32'd0;
        bus.bus_wstrb = (state == REQ && req_we) ? lane_strb : 4'b0000;
        bus.bus_wdata = (state == REQ) ? lane_wdata : 32'd0;
        core_done     = (state == FIN) || (state == ERR);
        core_err      = (state == ERR);
        core_busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Self-checking bench for mem_bus_bridge: directed scenarios followed by
// randomized accesses against a byte-lane model of RV32I loads and stores.
module tb_mem_bus_bridge;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [2:0]  core_funct3;
    logic [31:0] core_rdata;
    logic        core_done;
    logic        core_err;
    logic        core_busy;

    mem_bus_bridge_if bus_if();

    mem_bus_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_funct3 (core_funct3),
        .core_rdata  (core_rdata),
        .core_done   (core_done),
        .core_err    (core_err),
        .core_busy   (core_busy),
        .bus         (bus_if.master)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_rdata = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (byte-level view) ----------------
    function automatic bit m_err(input logic we, input logic [31:0] a, input logic [2:0] f);
        bit legal;
        bit mis;
        legal = (f == 3'd0 || f == 3'd1 || f == 3'd2) || ((f == 3'd4 || f == 3'd5) && !we);
        mis   = ((f == 3'd1 || f == 3'd5) && a[0]) || (f == 3'd2 && a[1:0] != 2'b00);
        return !legal || mis;
    endfunction

    function automatic logic [3:0] m_strb(input logic [31:0] a, input logic [2:0] f);
        logic [3:0] s;
        int sz;
        int base;
        sz   = 1 << f[1:0];
        base = int'(a[1:0]);
        for (int i = 0; i < 4; i++) s[i] = (i >= base) && (i < base + sz);
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [2:0] f);
        logic [31:0] w;
        int sz;
        sz = 1 << f[1:0];
        for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] word, input logic [31:0] a,
                                           input logic [2:0] f);
        logic [31:0] v;
        logic [31:0] mask;
        int sz;
        sz   = 1 << f[1:0];
        v    = word >> (8 * int'(a[1:0]));
        mask = (sz == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * sz)) - 64'd1);
        v    = v & mask;
        if (!f[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // Drive one complete access. d = bus_ready wait cycles, r = rvalid wait
    // cycles after the handshake; noise pokes core_req/bus_rvalid where they
    // must be ignored.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] f3, input int d, input int r,
                              input logic [31:0] word, input bit noise);
        core_req    = 1'b1;
        core_we     = we;
        core_addr   = addr;
        core_wdata  = wdata;
        core_funct3 = f3;
        tick();
        core_req = 1'b0;
        if (m_err(we, addr, f3)) begin
            check("err_done",  32'(core_done), 32'd1);
            check("err_err",   32'(core_err), 32'd1);
            check("err_valid", 32'(bus_if.bus_valid), 32'd0);
            check("err_rdata", core_rdata, exp_rdata);
            tick();
            check("err_after_done", 32'(core_done), 32'd0);
            check("err_after_busy", 32'(core_busy), 32'd0);
            return;
        end
        for (int i = 0; i <= d; i++) begin
            check("req_valid", 32'(bus_if.bus_valid), 32'd1);
            check("req_busy",  32'(core_busy), 32'd1);
            check("req_addr",  bus_if.bus_addr, {addr[31:2], 2'b00});
            check("req_we",    32'(bus_if.bus_we), 32'(we));
            check("req_wstrb", 32'(bus_if.bus_wstrb), we ? 32'(m_strb(addr, f3)) : 32'd0);
            if (we) check("req_wdata", bus_if.bus_wdata, m_wdata(wdata, f3));
            bus_if.bus_ready = (i == d);
            if (noise) begin
                core_req          = 1'($urandom_range(0, 1));
                core_we           = 1'($urandom_range(0, 1));
                core_addr         = $urandom;
                core_funct3       = 3'($urandom_range(0, 7));
                bus_if.bus_rvalid = 1'($urandom_range(0, 1));
                bus_if.bus_rdata  = $urandom;
            end
            tick();
        end
        bus_if.bus_ready  = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        core_req          = 1'b0;
        if (!we) begin
            for (int i = 0; i <= r; i++) begin
                check("resp_valid", 32'(bus_if.bus_valid), 32'd0);
                check("resp_done",  32'(core_done), 32'd0);
                bus_if.bus_rvalid = (i == r);
                bus_if.bus_rdata  = (i == r) ? word : $urandom;
                if (noise) core_req = 1'($urandom_range(0, 1));
                tick();
            end
            bus_if.bus_rvalid = 1'b0;
            core_req          = 1'b0;
            exp_rdata         = m_load(word, addr, f3);
        end
        check("fin_done",  32'(core_done), 32'd1);
        check("fin_err",   32'(core_err), 32'd0);
        check("fin_valid", 32'(bus_if.bus_valid), 32'd0);
        check("fin_rdata", core_rdata, exp_rdata);
        tick();
        check("idle_done", 32'(core_done), 32'd0);
        check("idle_busy", 32'(core_busy), 32'd0);
    endtask

    initial begin
        reset             = 1'b1;
        core_req          = 1'b0;
        core_we           = 1'b0;
        core_addr         = '0;
        core_wdata        = '0;
        core_funct3       = '0;
        bus_if.bus_ready  = 1'b0;
        bus_if.bus_rvalid = 1'b0;
        bus_if.bus_rdata  = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state.
        check("rst_valid", 32'(bus_if.bus_valid), 32'd0);
        check("rst_done",  32'(core_done), 32'd0);
        check("rst_err",   32'(core_err), 32'd0);
        check("rst_busy",  32'(core_busy), 32'd0);
        check("rst_rdata", core_rdata, 32'd0);
        check("rst_addr",  bus_if.bus_addr, 32'd0);
        check("rst_wstrb", 32'(bus_if.bus_wstrb), 32'd0);

        // SB 0xA5 to 0x1003, zero-wait.
        check("sb_model_strb", 32'(m_strb(32'h1003, F3_B)), 32'h8);
        run_access(1'b1, 32'h0000_1003, 32'h0000_00A5, F3_B, 0, 0, 32'd0, 1'b0);

        // LH / LHU from 0x2002, rvalid a few cycles after accept.
        run_access(1'b0, 32'h0000_2002, 32'd0, F3_H, 0, 2, 32'h8001_1234, 1'b1);
        check("lh_value", core_rdata, 32'hFFFF_8001);
        run_access(1'b0, 32'h0000_2002, 32'd0, F3_HU, 1, 2, 32'h8001_1234, 1'b1);
        check("lhu_value", core_rdata, 32'h0000_8001);

        // Misaligned word and illegal funct3.
        run_access(1'b0, 32'h0000_3001, 32'd0, F3_W, 0, 0, 32'd0, 1'b0);
        run_access(1'b0, 32'h0000_3000, 32'd0, 3'b110, 0, 0, 32'd0, 1'b0);
        run_access(1'b1, 32'h0000_3000, 32'd0, F3_BU, 0, 0, 32'd0, 1'b0);

        // Timeout: bus_ready never comes.
        begin
            int n;
            core_req = 1'b1; core_we = 1'b0; core_addr = 32'h5000; core_funct3 = F3_W;
            tick();
            core_req = 1'b0;
            n = 0;
            while (bus_if.bus_valid && n < 20) begin
                n++;
                tick();
            end
            check("tmo_valid_cycles", 32'(n), 32'd8);
            check("tmo_done", 32'(core_done), 32'd1);
            check("tmo_err",  32'(core_err), 32'd1);
            tick();
            check("tmo_after_valid", 32'(bus_if.bus_valid), 32'd0);
        end
        run_access(1'b1, 32'h0000_5000, 32'h1234_5678, F3_W, 2, 0, 32'd0, 1'b0);
        // Completion exactly at expiry still succeeds.
        run_access(1'b0, 32'h0000_5004, 32'd0, F3_W, 3, 3, 32'hCAFE_F00D, 1'b0);

        // Reset while waiting for the read response.
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h4000; core_funct3 = F3_W;
        tick();
        core_req         = 1'b0;
        bus_if.bus_ready = 1'b1;
        tick();
        bus_if.bus_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset             = 1'b0;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'h1234_5678;
        exp_rdata         = 32'd0;
        check("rstmid_done",  32'(core_done), 32'd0);
        check("rstmid_valid", 32'(bus_if.bus_valid), 32'd0);
        check("rstmid_busy",  32'(core_busy), 32'd0);
        check("rstmid_rdata", core_rdata, 32'd0);
        tick();
        bus_if.bus_rvalid = 1'b0;
        check("rstmid_late_done", 32'(core_done), 32'd0);
        check("rstmid_late_rdata", core_rdata, 32'd0);
        run_access(1'b0, 32'h0000_4000, 32'd0, F3_W, 0, 1, 32'hDEAD_BEEF, 1'b0);
        check("rstmid_lw", core_rdata, 32'hDEAD_BEEF);

        // Back-to-back: SW, then LW requested in the SW done cycle.
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h6000;
        core_wdata = 32'h1122_3344; core_funct3 = F3_W;
        tick();
        core_req         = 1'b0;
        bus_if.bus_ready = 1'b1;
        check("b2b_sw_valid", 32'(bus_if.bus_valid), 32'd1);
        tick();
        bus_if.bus_ready = 1'b0;
        check("b2b_sw_done", 32'(core_done), 32'd1);
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h6004; core_funct3 = F3_W;
        tick();
        core_req = 1'b0;
        check("b2b_lw_valid", 32'(bus_if.bus_valid), 32'd1);
        check("b2b_lw_addr",  bus_if.bus_addr, 32'h6004);
        check("b2b_lw_we",    32'(bus_if.bus_we), 32'd0);
        bus_if.bus_ready = 1'b1;
        tick();
        bus_if.bus_ready  = 1'b0;
        bus_if.bus_rvalid = 1'b1;
        bus_if.bus_rdata  = 32'h5566_7788;
        tick();
        bus_if.bus_rvalid = 1'b0;
        exp_rdata = 32'h5566_7788;
        check("b2b_lw_done",  32'(core_done), 32'd1);
        check("b2b_lw_rdata", core_rdata, exp_rdata);
        tick();

        // Randomized accesses.
        for (int k = 0; k < 60; k++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            run_access(we, a, $urandom, f3, $urandom_range(0, 3), $urandom_range(0, 3),
                       $urandom, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
